instr_mem_loadable: RTL and testbench
=====================================

INSTR_MEM_LOADABLE -- requirements
Module: instr_mem_loadable

Interface
REQ-001 SHALL have parameter ROM_SIZE, default 256: instruction word depth, power of two, 2..4096.
REQ-002 SHALL have parameter INSTR_WIDTH, default 9: instruction word width in bits.
REQ-003 SHALL have derived parameter ADDR_WIDTH, default $clog2(ROM_SIZE): fetch address width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-007 SHALL have port load_start, input, 1: begin a program load.
REQ-008 SHALL have port load_len, input, ADDR_WIDTH+1: word count of the program, sampled with load_start.
REQ-009 SHALL have port load_valid, input, 1: load_data holds a valid word this cycle.
REQ-010 SHALL have port load_data, input, INSTR_WIDTH: program word.
REQ-011 SHALL have port load_busy, output, 1: load in progress.
REQ-012 SHALL have port load_done, output, 1: one-cycle pulse, load complete.
REQ-013 SHALL have port fetch_req, input, 1: fetch request.
REQ-014 SHALL have port fetch_addr, input, ADDR_WIDTH: fetch word address.
REQ-015 SHALL have port fetch_ready, output, 1: fetches accepted this cycle.
REQ-016 SHALL have port instr_valid, output, 1: instr_out carries a fetch result.
REQ-017 SHALL have port instr_out, output, INSTR_WIDTH: fetched instruction.
REQ-018 SHALL have port addr_err, output, 1: fetch address beyond the loaded program.

Function
REQ-019 SHALL implement states IDLE, LOAD, RUN; reset enters IDLE.
REQ-020 IDLE: fetch_ready=0, load_busy=0; load_start -> LOAD, write pointer=0, captured length=load_len.
REQ-021 Captured length SHALL be clamped to ROM_SIZE when load_len > ROM_SIZE.
REQ-022 load_len=0 SHALL skip LOAD: go straight to RUN with load_done pulse next cycle, loaded length 0.
REQ-023 LOAD: load_busy=1, fetch_ready=0; each cycle with load_valid=1 writes load_data to mem[ptr], ptr+1; load_valid=0 cycles SHALL not advance ptr.
REQ-024 On the write of word index length-1, SHALL enter RUN; load_done=1 and fetch_ready=1 in the following cycle only; loaded length=captured length.
REQ-025 load_start during LOAD SHALL be ignored.
REQ-026 RUN: fetch_ready=1; fetch_req=1 at cycle N SHALL give instr_valid=1, instr_out=mem[fetch_addr] at cycle N+1 (1-cycle latency, throughput 1 per cycle).
REQ-027 fetch_addr >= loaded length SHALL give instr_valid=1, addr_err=1, instr_out=0 (NOP) at N+1.
REQ-028 Cycle without accepted fetch SHALL give instr_valid=0, addr_err=0 next cycle; instr_out holds its last value.
REQ-029 fetch_req while fetch_ready=0 SHALL be dropped (no instr_valid).
REQ-030 load_start in RUN SHALL enter LOAD (reload); a fetch_req in the same cycle SHALL be dropped.
REQ-031 Memory write and read SHALL be synchronous to clk; no combinational path from fetch_addr to instr_out.

Reset
REQ-032 Reset SHALL force IDLE, ptr=0, loaded length=0, all outputs 0.
REQ-033 Reset mid-load SHALL abort with no load_done; memory contents need not clear.
REQ-034 Reset has priority over all other inputs in the same cycle.

Verification
REQ-035 Reset; load_start with load_len=4; words 0x0C0,0x143,0x046,0x0F9 on 4 consecutive load_valid cycles -> load_done one-cycle pulse the cycle after the 4th write, fetch_ready=1 from then on.
REQ-036 After REQ-035, fetch_req addrs 0,1,2,3 back-to-back -> instr_valid 4 consecutive cycles, instr_out 0x0C0,0x143,0x046,0x0F9, addr_err=0.
REQ-037 Load len 3 with load_valid pattern 1,0,0,1,1 -> exactly 3 words stored at 0..2, load_done after 5th cycle.
REQ-038 After len-4 load, fetch addr 4 -> instr_valid=1, addr_err=1, instr_out=0x000.
REQ-039 Reset asserted after 2 of 4 load words -> load_busy=0, load_done never pulses, fetch_ready=0.
REQ-040 In RUN, load_start and fetch_req in same cycle -> next cycle instr_valid=0, load_busy=1.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: a streamed program load fills the array, then
// fetches return one word per cycle, or a NOP flagged with addr_err past the program end.
module instr_mem_loadable #(
  parameter int unsigned ROM_SIZE    = 256,
  parameter int unsigned INSTR_WIDTH = 9,
  parameter int unsigned ADDR_WIDTH  = $clog2(ROM_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic [ADDR_WIDTH:0]    load_len,
  input  logic                   load_valid,
  input  logic [INSTR_WIDTH-1:0] load_data,
  output logic                   load_busy,
  output logic                   load_done,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic                   fetch_ready,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   addr_err
);

  localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0] ROM_LEN = LEN_WIDTH'(ROM_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [ADDR_WIDTH-1:0]  ptr, ptr_next;
  logic [LEN_WIDTH-1:0]   cap_len, cap_len_next;
  logic [LEN_WIDTH-1:0]   loaded_len, loaded_len_next;
  logic                   load_done_next;
  logic                   load_busy_next;
  logic                   fetch_ready_next;

  logic [LEN_WIDTH-1:0]   len_clamped_c;
  logic                   last_word_c;
  logic                   addr_err_c;
  logic                   mem_we_c;
  logic                   fetch_accept_c;

  logic [INSTR_WIDTH-1:0] mem [ROM_SIZE];

  // Requested length saturates at the array depth.
  assign len_clamped_c = (load_len > ROM_LEN) ? ROM_LEN : load_len;
  assign last_word_c   = ({1'b0, ptr} == (cap_len - LEN_WIDTH'(1)));
  assign addr_err_c    = ({1'b0, fetch_addr} >= loaded_len);

  // Next-state and next-output logic.
  always_comb begin
    state_next      = state;
    ptr_next        = ptr;
    cap_len_next    = cap_len;
    loaded_len_next = loaded_len;
    load_done_next  = 1'b0;
    mem_we_c        = 1'b0;
    fetch_accept_c  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (load_start) begin
          ptr_next = '0;
          if (load_len == '0) begin
            state_next      = S_RUN;
            loaded_len_next = '0;
            load_done_next  = 1'b1;
          end else begin
            state_next   = S_LOAD;
            cap_len_next = len_clamped_c;
          end
        end
      end

      S_LOAD: begin
        if (load_valid) begin
          mem_we_c = 1'b1;
          ptr_next = ptr + ADDR_WIDTH'(1);
          if (last_word_c) begin
            state_next      = S_RUN;
            loaded_len_next = cap_len;
            load_done_next  = 1'b1;
          end
        end
      end

      S_RUN: begin
        // A reload takes precedence; any fetch in the same cycle is dropped.
        if (load_start) begin
          ptr_next = '0;
          if (load_len == '0) begin
            state_next      = S_RUN;
            loaded_len_next = '0;
            load_done_next  = 1'b1;
          end else begin
            state_next   = S_LOAD;
            cap_len_next = len_clamped_c;
          end
        end else begin
          fetch_accept_c = fetch_req;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    load_busy_next   = (state_next == S_LOAD);
    fetch_ready_next = (state_next == S_RUN);
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      cap_len     <= '0;
      loaded_len  <= '0;
      load_busy   <= 1'b0;
      load_done   <= 1'b0;
      fetch_ready <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      cap_len     <= cap_len_next;
      loaded_len  <= loaded_len_next;
      load_busy   <= load_busy_next;
      load_done   <= load_done_next;
      fetch_ready <= fetch_ready_next;
    end
  end

  // Instruction array: no reset so it maps onto a plain synchronous RAM.
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) begin
      mem[ptr] <= load_data;
    end
  end

  // Registered fetch port; instr_out holds between accepted fetches.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
      instr_out   <= '0;
    end else begin
      instr_valid <= fetch_accept_c;
      addr_err    <= fetch_accept_c & addr_err_c;
      if (fetch_accept_c) begin
        instr_out <= addr_err_c ? '0 : mem[fetch_addr];
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scenario bench for instr_mem_loadable: a reference memory model feeds an
// expected-result queue that is drained as fetch results come back.
module tb_instr_mem_loadable;

  localparam int unsigned ROM_SIZE = 16;
  localparam int unsigned IW       = 9;
  localparam int unsigned AW       = $clog2(ROM_SIZE);

  typedef struct packed {
    logic          err;
    logic [IW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          load_valid;
  logic [IW-1:0] load_data;
  logic          load_busy;
  logic          load_done;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          instr_valid;
  logic [IW-1:0] instr_out;
  logic          addr_err;

  logic [IW-1:0] model_mem [ROM_SIZE];
  int unsigned   model_len;
  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  logic [IW-1:0] basic_words [4];
  logic [IW-1:0] gap_data [5];
  logic          gap_valid [5];

  instr_mem_loadable #(
    .ROM_SIZE    (ROM_SIZE),
    .INSTR_WIDTH (IW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_len    (load_len),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model_fetch(input logic [AW-1:0] a);
    exp_t e;
    e.err  = (32'(a) >= model_len);
    e.data = e.err ? '0 : model_mem[a];
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1; load_start = 1'b0; load_len = '0; load_valid = 1'b0;
    load_data = '0; fetch_req = 1'b0; fetch_addr = '0;
    step(); step();
    reset = 1'b0;
    n_cmp++; if (load_busy !== 1'b0) begin n_bad++; $display("FAIL rst_load_busy: got %b want 0", load_busy); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL rst_load_done: got %b want 0", load_done); end
    n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL rst_fetch_ready: got %b want 0", fetch_ready); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
    n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL rst_addr_err: got %b want 0", addr_err); end
    n_cmp++; if (instr_out !== '0) begin n_bad++; $display("FAIL rst_instr_out: got %h want 000", instr_out); end
    // Fetch in IDLE must be dropped
    fetch_req = 1'b1; fetch_addr = '0;
    step();
    fetch_req = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL idle_fetch_dropped: got %b want 0", instr_valid); end
  endtask

  task automatic test_load_basic();
    basic_words[0] = 9'h0C0; basic_words[1] = 9'h143;
    basic_words[2] = 9'h046; basic_words[3] = 9'h0F9;
    load_start = 1'b1; load_len = (AW+1)'(4);
    step();
    load_start = 1'b0;
    n_cmp++; if (load_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", load_busy); end
    n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_in_load: got %b want 0", fetch_ready); end
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = basic_words[i]; model_mem[i] = basic_words[i];
      step();
      n_cmp++; if (load_done !== (i == 3)) begin n_bad++; $display("FAIL basic_done[%0d]: got %b want %b", i, load_done, (i == 3)); end
    end
    load_valid = 1'b0; load_data = 9'h1FF; model_len = 4;
    n_cmp++; if (fetch_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %b want 1", fetch_ready); end
    n_cmp++; if (load_busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %b want 0", load_busy); end
    step();
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", load_done); end
    n_cmp++; if (fetch_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_hold: got %b want 1", fetch_ready); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; fetch_addr = AW'(i); sb.push_back(model_fetch(AW'(i)));
      step();
      e = sb.pop_front();
      n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, instr_valid); end
      n_cmp++; if ({addr_err, instr_out} !== {e.err, e.data}) begin n_bad++; $display("FAIL b2b_data[%0d]: got err=%b instr=%h want err=%b instr=%h", i, addr_err, instr_out, e.err, e.data); end
    end
    fetch_req = 1'b0;
    step();
    n_cmp++; if (instr_valid !== 1'b0 || addr_err !== 1'b0) begin n_bad++; $display("FAIL idle_cycle: got valid=%b err=%b want 0/0", instr_valid, addr_err); end
    n_cmp++; if (instr_out !== 9'h0F9) begin n_bad++; $display("FAIL instr_hold: got %h want 0f9", instr_out); end
  endtask

  task automatic test_addr_err();
    exp_t e;
    logic [AW-1:0] addrs [3];
    addrs[0] = AW'(4); addrs[1] = AW'(15); addrs[2] = AW'(2);
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; fetch_addr = addrs[i]; sb.push_back(model_fetch(addrs[i]));
      step();
      e = sb.pop_front();
      n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL err_valid[%0d]: got %b want 1", i, instr_valid); end
      n_cmp++; if ({addr_err, instr_out} !== {e.err, e.data}) begin n_bad++; $display("FAIL err_data[%0d]: got err=%b instr=%h want err=%b instr=%h", i, addr_err, instr_out, e.err, e.data); end
    end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_gapped_load();
    exp_t e;
    int   w;
    gap_valid[0] = 1'b1; gap_valid[1] = 1'b0; gap_valid[2] = 1'b0; gap_valid[3] = 1'b1; gap_valid[4] = 1'b1;
    gap_data[0] = 9'h111; gap_data[1] = 9'h1EE; gap_data[2] = 9'h1DD; gap_data[3] = 9'h022; gap_data[4] = 9'h133;
    load_start = 1'b1; load_len = (AW+1)'(3);
    step();
    load_start = 1'b0; w = 0;
    for (int c = 0; c < 5; c++) begin
      load_valid = gap_valid[c]; load_data = gap_data[c];
      if (gap_valid[c]) begin model_mem[w] = gap_data[c]; w++; end
      step();
      n_cmp++; if (load_done !== (c == 4)) begin n_bad++; $display("FAIL gap_done[%0d]: got %b want %b", c, load_done, (c == 4)); end
    end
    load_valid = 1'b0; model_len = 3;
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; fetch_addr = AW'(i); sb.push_back(model_fetch(AW'(i)));
      step();
      e = sb.pop_front();
      n_cmp++; if (instr_valid !== 1'b1 || {addr_err, instr_out} !== {e.err, e.data}) begin n_bad++; $display("FAIL gap_fetch[%0d]: got v=%b err=%b instr=%h want v=1 err=%b instr=%h", i, instr_valid, addr_err, instr_out, e.err, e.data); end
    end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_reload_drop();
    exp_t e;
    load_start = 1'b1; load_len = (AW+1)'(2); fetch_req = 1'b1; fetch_addr = '0;
    step();
    load_start = 1'b0; fetch_req = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reload_fetch_dropped: got %b want 0", instr_valid); end
    n_cmp++; if (load_busy !== 1'b1) begin n_bad++; $display("FAIL reload_busy: got %b want 1", load_busy); end
    n_cmp++; if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL reload_ready: got %b want 0", fetch_ready); end
    // A new load_start mid-load must not change the captured length
    load_start = 1'b1; load_len = (AW+1)'(1);
    load_valid = 1'b1; load_data = 9'h155; model_mem[0] = 9'h155;
    step();
    load_start = 1'b0;
    n_cmp++; if (load_done !== 1'b0 || load_busy !== 1'b1) begin n_bad++; $display("FAIL reload_ignore_start: got done=%b busy=%b want 0/1", load_done, load_busy); end
    load_data = 9'h0AA; model_mem[1] = 9'h0AA;
    step();
    load_valid = 1'b0; model_len = 2;
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL reload_done: got %b want 1", load_done); end
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; fetch_addr = AW'(i); sb.push_back(model_fetch(AW'(i)));
      step();
      e = sb.pop_front();
      n_cmp++; if (instr_valid !== 1'b1 || {addr_err, instr_out} !== {e.err, e.data}) begin n_bad++; $display("FAIL reload_fetch[%0d]: got v=%b err=%b instr=%h want v=1 err=%b instr=%h", i, instr_valid, addr_err, instr_out, e.err, e.data); end
    end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_clamp_random();
    exp_t e;
    logic req;
    load_start = 1'b1; load_len = (AW+1)'(20);
    step();
    load_start = 1'b0;
    for (int i = 0; i < ROM_SIZE; i++) begin
      load_valid = 1'b1; load_data = IW'($urandom); model_mem[i] = load_data;
      step();
      n_cmp++; if (load_done !== (i == ROM_SIZE - 1)) begin n_bad++; $display("FAIL clamp_done[%0d]: got %b want %b", i, load_done, (i == ROM_SIZE - 1)); end
    end
    load_valid = 1'b0; model_len = ROM_SIZE;
    for (int k = 0; k < 40; k++) begin
      req = ($urandom_range(0, 3) != 0);
      fetch_req = req; fetch_addr = AW'($urandom_range(0, ROM_SIZE - 1));
      if (req) sb.push_back(model_fetch(fetch_addr));
      step();
      n_cmp++; if (instr_valid !== req) begin n_bad++; $display("FAIL rand_valid[%0d]: got %b want %b", k, instr_valid, req); end
      if (req && sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++; if ({addr_err, instr_out} !== {e.err, e.data}) begin n_bad++; $display("FAIL rand_data[%0d]: got err=%b instr=%h want err=%b instr=%h", k, addr_err, instr_out, e.err, e.data); end
      end
    end
    fetch_req = 1'b0;
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drained: got %0d want 0", sb.size()); end
    step();
  endtask

  task automatic test_reset_mid_load();
    load_start = 1'b1; load_len = (AW+1)'(4);
    step();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = IW'(9'h060 + i);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      fetch_req = 1'b1; fetch_addr = '0;
      n_cmp++; if (load_busy !== 1'b0 || load_done !== 1'b0 || fetch_ready !== 1'b0) begin n_bad++; $display("FAIL abort_state[%0d]: got busy=%b done=%b ready=%b want 0/0/0", c, load_busy, load_done, fetch_ready); end
      step();
      n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL abort_fetch[%0d]: got %b want 0", c, instr_valid); end
    end
    load_valid = 1'b0; fetch_req = 1'b0;
    step();
  endtask

  task automatic test_zero_len();
    exp_t e;
    load_start = 1'b1; load_len = '0;
    step();
    load_start = 1'b0; model_len = 0;
    n_cmp++; if (load_done !== 1'b1 || fetch_ready !== 1'b1 || load_busy !== 1'b0) begin n_bad++; $display("FAIL zero_done: got done=%b ready=%b busy=%b want 1/1/0", load_done, fetch_ready, load_busy); end
    fetch_req = 1'b1; fetch_addr = '0; sb.push_back(model_fetch('0));
    step();
    fetch_req = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL zero_done_pulse: got %b want 0", load_done); end
    n_cmp++; if (instr_valid !== 1'b1 || {addr_err, instr_out} !== {e.err, e.data}) begin n_bad++; $display("FAIL zero_fetch: got v=%b err=%b instr=%h want v=1 err=%b instr=%h", instr_valid, addr_err, instr_out, e.err, e.data); end
    step();
  endtask

  initial begin
    model_len = 0;
    test_reset();
    test_load_basic();
    test_back_to_back();
    test_addr_err();
    test_gapped_load();
    test_reload_drop();
    test_clamp_random();
    test_reset_mid_load();
    test_zero_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
